// File: rtl/led_pkg.sv
// Shared constants for the board LED blinker: oscillator frequency, default
// terminal count and a helper that turns a half-period in ms into a terminal count.
package led_pkg;

    localparam int unsigned CLK_HZ = 32'd50_000_000;
    localparam logic [24:0] BLINK_CNT_MAX = 25'd24999999;

    // Terminal count giving one LED toggle every 'ms' milliseconds.
    function automatic int unsigned cnt_max_from_ms(input int unsigned ms);
        return (CLK_HZ / 32'd1000) * ms - 32'd1;
    endfunction

endpackage

// File: rtl/led_blinker_if.sv
// LED drive bundle: the blinker is the master, the board pin (or a bench) the slave.
interface led_blinker_if;

    logic light;

    modport master (output light);
    modport slave  (input  light);

endinterface

// File: rtl/tick_counter.sv
// Terminal counter: counts 0..MAX and wraps, raising tick while the count
// sits at MAX so the consumer acts on the same edge as the wrap.
module tick_counter #(
    parameter int unsigned W = 25,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         tick_s;

    assign tick_s = (cnt_r == MAX);
    assign tick   = tick_s;

    // Next count: wrap to zero at the terminal value, otherwise increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (tick_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    tick_counter_chk #(
        .W   (W),
        .MAX (MAX)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_r)
    );

endmodule

// File: rtl/tick_counter_chk.sv
// Property checker for tick_counter: the count must never leave 0..MAX.
module tick_counter_chk #(
    parameter int unsigned W = 25,
    parameter logic [W-1:0] MAX = '1
) (
    input logic         clk,
    input logic         rst_n,
    input logic [W-1:0] cnt
);

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= MAX);

endmodule

// File: rtl/led_blinker.sv
// Free-running LED blinker: the LED flop toggles once per terminal-counter
// period, giving a 50% square wave of period 2*(cnt_max+1) clocks.
module led_blinker
    import led_pkg::*;
#(
    parameter int unsigned CNT_W = 25,
    parameter logic [CNT_W-1:0] cnt_max = BLINK_CNT_MAX
) (
    input  logic          clk50m,
    input  logic          rst,
    led_blinker_if.master led
);

    logic tick_s;
    logic light_r;
    logic light_nxt_s;

    tick_counter #(
        .W   (CNT_W),
        .MAX (cnt_max)
    ) u_cnt (
        .clk   (clk50m),
        .rst_n (rst),
        .tick  (tick_s)
    );

    // Toggle on the wrap edge, otherwise hold.
    always_comb begin
        light_nxt_s = light_r;
        if (tick_s) begin
            light_nxt_s = ~light_r;
        end else begin
            light_nxt_s = light_r;
        end
    end

    // LED drive flop; the pin sees only this register.
    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst) begin
            light_r <= 1'b0;
        end else begin
            light_r <= light_nxt_s;
        end
    end

    assign led.light = light_r;

endmodule

// File: tb/tb_led_blinker.sv
// Bench for led_blinker: four instances (terminal counts 4, 0, 249 and default)
// compared every cycle against an arithmetic model of edges since reset release.
module tb_led_blinker;

    logic clk50m = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #10 clk50m = ~clk50m;

    led_blinker_if if_a ();
    led_blinker_if if_b ();
    led_blinker_if if_c ();
    led_blinker_if if_d ();

    led_blinker #(.CNT_W(25), .cnt_max(25'd4))   dut_a (.clk50m(clk50m), .rst(rst), .led(if_a));
    led_blinker #(.CNT_W(25), .cnt_max(25'd0))   dut_b (.clk50m(clk50m), .rst(rst), .led(if_b));
    led_blinker #(.CNT_W(25), .cnt_max(25'd249)) dut_c (.clk50m(clk50m), .rst(rst), .led(if_c));
    led_blinker dut_d (.clk50m(clk50m), .rst(rst), .led(if_d));

    logic        lights [4];
    logic [24:0] cnts   [4];
    longint      mx     [4] = '{64'd4, 64'd0, 64'd249, 64'd24999999};

    assign lights[0] = if_a.light;
    assign lights[1] = if_b.light;
    assign lights[2] = if_c.light;
    assign lights[3] = if_d.light;
    assign cnts[0]   = dut_a.u_cnt.cnt_r;
    assign cnts[1]   = dut_b.u_cnt.cnt_r;
    assign cnts[2]   = dut_c.u_cnt.cnt_r;
    assign cnts[3]   = dut_d.u_cnt.cnt_r;

    // After k edges out of reset, the LED has toggled floor(k/(M+1)) times.
    function automatic logic exp_light(input longint k, input longint m);
        return ((k / (m + 64'd1)) % 64'd2) == 64'd1;
    endfunction

    function automatic logic [24:0] exp_cnt(input longint k, input longint m);
        return 25'(k % (m + 64'd1));
    endfunction

    task automatic assert_rst(input int hold);
        @(negedge clk50m);
        #($urandom_range(1, 6));
        rst = 1'b0;
        repeat (hold) @(posedge clk50m);
    endtask

    task automatic release_rst();
        @(negedge clk50m);
        #($urandom_range(1, 6));
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk50m);
            for (int i = 0; i < 4; i++) begin
                total++;
                if (lights[i] !== 1'b0 || cnts[i] !== 25'd0) begin
                    bad++;
                    $display("FAIL reset_hold inst=%0d cycle=%0d light=%b cnt=%0d, required light=0 cnt=0",
                             i, c, lights[i], cnts[i]);
                end
            end
        end
    endtask

    task automatic test_small();
        int n;
        assert_rst(int'($urandom_range(2, 8)));
        release_rst();
        n = int'($urandom_range(30, 45));
        for (int k = 1; k <= n; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            total++;
            if (lights[0] !== exp_light(k, mx[0]) || cnts[0] !== exp_cnt(k, mx[0])) begin
                bad++;
                $display("FAIL small_count edge=%0d light=%b cnt=%0d, required light=%b cnt=%0d",
                         k, lights[0], cnts[0], exp_light(k, mx[0]), exp_cnt(k, mx[0]));
            end
        end
    endtask

    task automatic test_zero();
        assert_rst(int'($urandom_range(2, 8)));
        release_rst();
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            total++;
            if (lights[1] !== k[0] || cnts[1] !== 25'd0) begin
                bad++;
                $display("FAIL zero_count edge=%0d light=%b cnt=%0d, required light=%b cnt=0",
                         k, lights[1], cnts[1], k[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int hold;
        assert_rst(3);
        release_rst();
        repeat (6) @(posedge clk50m);
        @(negedge clk50m);
        total++;
        if (lights[0] !== 1'b1 || cnts[0] !== 25'd1) begin
            bad++;
            $display("FAIL mid_reset_pre light=%b cnt=%0d, required light=1 cnt=1", lights[0], cnts[0]);
        end
        #($urandom_range(1, 6));
        rst = 1'b0;
        #1;
        total++;
        if (lights[0] !== 1'b0 || cnts[0] !== 25'd0) begin
            bad++;
            $display("FAIL mid_reset_async light=%b cnt=%0d, required light=0 cnt=0", lights[0], cnts[0]);
        end
        hold = int'($urandom_range(2, 10));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk50m);
            total++;
            if (lights[0] !== 1'b0 || cnts[0] !== 25'd0) begin
                bad++;
                $display("FAIL mid_reset_hold cycle=%0d light=%b cnt=%0d, required light=0 cnt=0",
                         c, lights[0], cnts[0]);
            end
        end
        release_rst();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            total++;
            if (lights[0] !== exp_light(k, mx[0]) || cnts[0] !== exp_cnt(k, mx[0])) begin
                bad++;
                $display("FAIL mid_reset_restart edge=%0d light=%b cnt=%0d, required light=%b cnt=%0d",
                         k, lights[0], cnts[0], exp_light(k, mx[0]), exp_cnt(k, mx[0]));
            end
        end
    endtask

    task automatic test_wrap();
        assert_rst(int'($urandom_range(1, 5)));
        release_rst();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            total++;
            if (cnts[0] !== exp_cnt(k, mx[0]) || cnts[0] > 25'd4) begin
                bad++;
                $display("FAIL wrap edge=%0d cnt=%0d, required %0d", k, cnts[0], exp_cnt(k, mx[0]));
            end
        end
    endtask

    // Scaled-down version of the multi-second run: four toggles at multiples of M+1.
    task automatic test_long();
        int   edges[$];
        logic prev;
        assert_rst(200);
        release_rst();
        prev = lights[2];
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            if (lights[2] !== prev) edges.push_back(k);
            prev = lights[2];
        end
        total++;
        if (edges.size() != 4) begin
            bad++;
            $display("FAIL long_toggle_count got=%0d, required 4", edges.size());
        end
        for (int j = 0; j < edges.size() && j < 4; j++) begin
            total++;
            if (edges[j] != 250 * (j + 1)) begin
                bad++;
                $display("FAIL long_toggle_edge idx=%0d got=%0d, required %0d", j, edges[j], 250 * (j + 1));
            end
        end
        total++;
        if (lights[2] !== 1'b0) begin
            bad++;
            $display("FAIL long_final light=%b, required 0", lights[2]);
        end
    endtask

    task automatic test_default();
        int n;
        assert_rst(200);
        release_rst();
        n = int'($urandom_range(300, 600));
        for (int k = 1; k <= n; k++) begin
            @(posedge clk50m);
            @(negedge clk50m);
            total++;
            if (lights[3] !== 1'b0 || cnts[3] !== exp_cnt(k, mx[3])) begin
                bad++;
                $display("FAIL default_count edge=%0d light=%b cnt=%0d, required light=0 cnt=%0d",
                         k, lights[3], cnts[3], exp_cnt(k, mx[3]));
            end
        end
    endtask

    task automatic test_random_restarts();
        int n;
        for (int r = 0; r < 6; r++) begin
            assert_rst(int'($urandom_range(1, 5)));
            release_rst();
            n = int'($urandom_range(5, 60));
            for (int k = 1; k <= n; k++) begin
                @(posedge clk50m);
                @(negedge clk50m);
                for (int i = 0; i < 4; i++) begin
                    total++;
                    if (lights[i] !== exp_light(k, mx[i]) || cnts[i] !== exp_cnt(k, mx[i])) begin
                        bad++;
                        $display("FAIL random_restart round=%0d inst=%0d edge=%0d light=%b cnt=%0d, required light=%b cnt=%0d",
                                 r, i, k, lights[i], cnts[i], exp_light(k, mx[i]), exp_cnt(k, mx[i]));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_zero();
        test_mid_reset();
        test_wrap();
        test_long();
        test_default();
        test_random_restarts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
Name: led_blinker

Overview:
- Free-running LED blinker clocked from the 50 MHz board oscillator.
- A terminal counter divides the clock. The single LED output toggles once per counter period, giving a square wave.
- With the default parameter, the LED toggles every 0.5 s, a 1 Hz blink.
- Top-level leaf block driving a board LED pin directly; no handshake with other logic.

Parameters:
- cnt_max, 25'd24999999, terminal count. The LED toggles every cnt_max+1 clock cycles. Legal range is 0 to 2^25-1.
- CNT_W, 25, counter width in bits. Must satisfy 2^CNT_W > cnt_max.

Ports:
- clk50m  input  1  system clock, 50 MHz nominal; all logic on the rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets).
- light  output  1  LED drive, registered; 1 = LED on.

Behaviour:
- State:
  - cnt, CNT_W-bit unsigned counter.
  - light, 1-bit register; drives the port directly, with no combinational path.
- Reset, while rst=0, applied asynchronously regardless of clock: cnt=0 and light=0. Both hold while rst stays low.
- Each rising clk50m edge with rst=1:
  - if cnt==cnt_max: cnt<=0 and light<=~light, in the same edge.
  - else: cnt<=cnt+1 and light holds.
- Tick: internal one-cycle pulse, high combinationally when cnt==cnt_max.
- Timing from reset release:
  - The first rising edge after release sees cnt=0.
  - light first goes 0->1 on the (cnt_max+1)-th rising edge.
  - light then toggles every cnt_max+1 edges thereafter.
  - Output period is 2*(cnt_max+1) cycles at 50% duty.
- Default timing: toggle every 25,000,000 cycles (500 ms), period 1 s. A 2 s run after release gives exactly 4 toggles; light ends at 0.
- Wrap: the counter never exceeds cnt_max. No overflow path; values above cnt_max are unreachable.
- cnt_max=0: light toggles on every clock edge (period 2 cycles); cnt stays 0.
- Reset mid-count: cnt and light clear immediately. The timing restarts from zero on release.
- Reset released coincident with a clock edge: implementation-defined which edge counts first. The bench must allow ±1 cycle there only.
- No enable input; the block always runs when out of reset.

Decomposition:
- Shared package led_pkg:
  - localparam CLK_HZ=50_000_000.
  - default BLINK_CNT_MAX=25'd24999999.
  - function to compute cnt_max from a half-period in ms, cnt_max = CLK_HZ/1000*ms - 1.
- Sub-module tick_counter, parameters MAX and W:
  - Ports: clk, async active-low rst_n, output tick.
  - Wraps at MAX.
- led_blinker instantiates tick_counter and holds only the light toggle flop.

Test Plan:
- Reset hold: rst=0 for 200 cycles, clk running -> light=0 and cnt=0 throughout.
- Small count, cnt_max=4; release rst:
  - light rises on edge 5, falls on edge 10, rises on edge 15.
  - Period 10 cycles, high time exactly 5 cycles.
- cnt_max=0 -> light toggles every rising edge after release, starting 0->1 on edge 1.
- Mid-operation reset, cnt_max=4:
  - Assert rst=0 asynchronously (between edges) at edge 7, when light=1 and cnt=1.
  - light=0 and cnt=0 immediately, before the next edge.
  - After release, the first rise is again 5 edges later.
- Default parameter, 2e9 ns simulation after a 200-cycle reset:
  - Exactly 4 light transitions, at 500 ms, 1 s, 1.5 s and 2 s after release (±1 cycle).
  - Final light=0.
- Wrap check, cnt_max=4: cnt sequence 0,1,2,3,4,0,1 with no value >4 over 100 cycles. Verified by assertion cnt<=cnt_max every cycle.
